// File: rtl/rf_arb_pkg.sv
// rf_arb_pkg: shared definitions for the register-file writeback arbiter.
//   RF_ARB_ADDR_W / RF_ARB_DATA_W : default address / data widths
//   req_id_e                      : requester identity (ALU writeback, load writeback)
//   slot_t                        : per-slot status seen by the grant logic
package rf_arb_pkg;

    localparam int RF_ARB_ADDR_W = 5;
    localparam int RF_ARB_DATA_W = 32;

    typedef enum logic {
        REQ_ALU = 1'b0,
        REQ_LSU = 1'b1
    } req_id_e;

    // valid: slot holds a pending write
    // old  : entry is strictly older than the entry in the other slot
    typedef struct packed {
        logic valid;
        logic old;
    } slot_t;

endpackage

// File: rtl/rf_arb_slot.sv
// rf_arb_slot: one-entry writeback holding slot with relative-age tracking.
// Ports:
//   clk, reset    : clock, asynchronous active-high reset
//   in_valid      : requester offers a write
//   in_addr/data  : requester write address / data
//   grant         : arbiter drains this slot on the current cycle
//   other_accept  : the other slot takes a new entry on the current edge
//   ready         : slot can take a write this cycle (empty or being drained)
//   accept        : handshake completes on the coming edge
//   status        : valid / older flags for the grant logic
//   addr, data    : stored write
module rf_arb_slot
    import rf_arb_pkg::*;
#(
    parameter int ADDR_W = RF_ARB_ADDR_W,
    parameter int DATA_W = RF_ARB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              grant,
    input  logic              other_accept,
    output logic              ready,
    output logic              accept,
    output slot_t             status,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data
);

    logic occupied;
    logic older;

    // ready comes only from registered state and the grant, never from in_valid
    assign ready  = !occupied || grant;
    assign accept = in_valid && ready;

    assign status.valid = occupied;
    assign status.old   = older;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occupied <= 1'b0;
            older    <= 1'b0;
            addr     <= '0;
            data     <= '0;
        end else if (accept) begin
            // a fresh entry is never older than anything
            occupied <= 1'b1;
            older    <= 1'b0;
            addr     <= in_addr;
            data     <= in_data;
        end else if (grant) begin
            occupied <= 1'b0;
            older    <= 1'b0;
        end else begin
            // a waiting entry becomes older once the other slot takes something newer
            older <= occupied && (older || other_accept);
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: two-requester writeback arbiter for one register-file write port.
// Requester 0 is the ALU writeback, requester 1 the load writeback. Each owns a
// one-entry slot; the older slot wins, equal ages fall back to round-robin.
// Ports:
//   clk, reset                          : clock, asynchronous active-high reset
//   wb0_valid/ready/addr/data           : requester 0 valid-ready write channel
//   wb1_valid/ready/addr/data           : requester 1 valid-ready write channel
//   rg_wrt_en/rg_wrt_addr/rg_wrt_data   : registered register-file write port
//   idle                                : both slots empty and no write issuing
// Build option:
//   RF_ARB_X0_DROP_EN : writes to address 0 consume their grant but never raise rg_wrt_en
module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int ADDR_W = RF_ARB_ADDR_W,
    parameter int DATA_W = RF_ARB_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wb0_valid,
    output logic              wb0_ready,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    input  logic              wb1_valid,
    output logic              wb1_ready,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              rg_wrt_en,
    output logic [ADDR_W-1:0] rg_wrt_addr,
    output logic [DATA_W-1:0] rg_wrt_data,
    output logic              idle
);

    slot_t             s0_status, s1_status;
    logic [ADDR_W-1:0] s0_addr, s1_addr;
    logic [DATA_W-1:0] s0_data, s1_data;
    logic              s0_accept, s1_accept;
    logic              grant0, grant1, any_grant;
    req_id_e           gnt_id;
    req_id_e           rr_ptr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              drop_write;

    rf_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot0 (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (wb0_valid),
        .in_addr      (wb0_addr),
        .in_data      (wb0_data),
        .grant        (grant0),
        .other_accept (s1_accept),
        .ready        (wb0_ready),
        .accept       (s0_accept),
        .status       (s0_status),
        .addr         (s0_addr),
        .data         (s0_data)
    );

    rf_arb_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot1 (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (wb1_valid),
        .in_addr      (wb1_addr),
        .in_data      (wb1_data),
        .grant        (grant1),
        .other_accept (s0_accept),
        .ready        (wb1_ready),
        .accept       (s1_accept),
        .status       (s1_status),
        .addr         (s1_addr),
        .data         (s1_data)
    );

    always_comb begin
        gnt_id = REQ_ALU;
        if (s0_status.valid && s1_status.valid) begin
            if (s0_status.old != s1_status.old) begin
                gnt_id = s0_status.old ? REQ_ALU : REQ_LSU;
            end else begin
                gnt_id = rr_ptr;
            end
        end else if (s1_status.valid) begin
            gnt_id = REQ_LSU;
        end
    end

    assign any_grant = s0_status.valid || s1_status.valid;
    assign grant0    = any_grant && (gnt_id == REQ_ALU);
    assign grant1    = any_grant && (gnt_id == REQ_LSU);
    assign sel_addr  = grant1 ? s1_addr : s0_addr;
    assign sel_data  = grant1 ? s1_data : s0_data;

`ifdef RF_ARB_X0_DROP_EN
    assign drop_write = (sel_addr == '0);
`else
    assign drop_write = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= REQ_ALU;
            rg_wrt_en   <= 1'b0;
            rg_wrt_addr <= '0;
            rg_wrt_data <= '0;
        end else begin
            if (any_grant) begin
                rr_ptr <= (gnt_id == REQ_ALU) ? REQ_LSU : REQ_ALU;
            end
            // a dropped write still drains its slot; the port just stays quiet
            if (any_grant && !drop_write) begin
                rg_wrt_en   <= 1'b1;
                rg_wrt_addr <= sel_addr;
                rg_wrt_data <= sel_data;
            end else begin
                rg_wrt_en <= 1'b0;
            end
        end
    end

    assign idle = !s0_status.valid && !s1_status.valid && !rg_wrt_en;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

`ifdef RF_ARB_X0_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wb0_valid = 1'b0, wb1_valid = 1'b0;
    logic          wb0_ready, wb1_ready;
    logic [AW-1:0] wb0_addr = '0, wb1_addr = '0;
    logic [DW-1:0] wb0_data = '0, wb1_data = '0;
    logic          rg_wrt_en;
    logic [AW-1:0] rg_wrt_addr;
    logic [DW-1:0] rg_wrt_data;
    logic          idle;

    int n_chk = 0;
    int n_err = 0;

    rf_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .wb0_valid   (wb0_valid),
        .wb0_ready   (wb0_ready),
        .wb0_addr    (wb0_addr),
        .wb0_data    (wb0_data),
        .wb1_valid   (wb1_valid),
        .wb1_ready   (wb1_ready),
        .wb1_addr    (wb1_addr),
        .wb1_data    (wb1_data),
        .rg_wrt_en   (rg_wrt_en),
        .rg_wrt_addr (rg_wrt_addr),
        .rg_wrt_data (rg_wrt_data),
        .idle        (idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          v1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          r0;
        logic          r1;
        logic          idl;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                input logic en, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                                input logic r0, input logic r1, input logic idl);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.en = en; v.addr = addr; v.data = data;
        v.r0 = r0; v.r1 = r1; v.idl = idl;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
        wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic chk_port(input string tag, input logic en, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data);
        chk({tag, ".en"}, 64'(rg_wrt_en), 64'(en));
        chk({tag, ".addr"}, 64'(rg_wrt_addr), 64'(addr));
        chk({tag, ".data"}, 64'(rg_wrt_data), 64'(data));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(1, 3, 32'hDEADBEEF, 0, 0, 0,     0, 0, 32'h0,        1, 1, 0);
        vecs[1]  = mk(0, 0, 0,            0, 0, 0,     1, 3, 32'hDEADBEEF, 1, 1, 0);
        vecs[2]  = mk(0, 0, 0,            0, 0, 0,     0, 3, 32'hDEADBEEF, 1, 1, 1);
        vecs[3]  = mk(1, 5, 32'h11,       1, 5, 32'h22, 0, 3, 32'hDEADBEEF, 0, 1, 0);
        vecs[4]  = mk(0, 0, 0,            0, 0, 0,     1, 5, 32'h22,       1, 1, 0);
        vecs[5]  = mk(0, 0, 0,            0, 0, 0,     1, 5, 32'h11,       1, 1, 0);
        vecs[6]  = mk(1, 7, 32'h70,       0, 0, 0,     0, 5, 32'h11,       1, 1, 0);
        vecs[7]  = mk(1, 8, 32'h80,       0, 0, 0,     1, 7, 32'h70,       1, 1, 0);
        vecs[8]  = mk(1, 9, 32'h90,       0, 0, 0,     1, 8, 32'h80,       1, 1, 0);
        vecs[9]  = mk(0, 0, 0,            0, 0, 0,     1, 9, 32'h90,       1, 1, 0);
        vecs[10] = mk(0, 0, 0,            1, 0, 32'hA5, 0, 9, 32'h90,       1, 1, 0);
        vecs[11] = mk(0, 0, 0,            0, 0, 0,     !DROP, DROP ? 5'd9 : 5'd0,
                      DROP ? 32'h90 : 32'hA5, 1, 1, DROP);
        vecs[12] = mk(0, 0, 0,            0, 0, 0,     0, DROP ? 5'd9 : 5'd0,
                      DROP ? 32'h90 : 32'hA5, 1, 1, 1);

        // reset state
        do_reset();
        chk_port("reset", 0, 0, 0);
        chk("reset.wb0_ready", 64'(wb0_ready), 1);
        chk("reset.wb1_ready", 64'(wb1_ready), 1);
        chk("reset.idle", 64'(idle), 1);

        // table: single write, pointer-decided contention, streaming, address 0
        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].v0, vecs[i].a0, vecs[i].d0, vecs[i].v1, vecs[i].a1, vecs[i].d1);
            tick();
            chk_port($sformatf("vec%0d", i), vecs[i].en, vecs[i].addr, vecs[i].data);
            chk($sformatf("vec%0d.wb0_ready", i), 64'(wb0_ready), 64'(vecs[i].r0));
            chk($sformatf("vec%0d.wb1_ready", i), 64'(wb1_ready), 64'(vecs[i].r1));
            chk($sformatf("vec%0d.idle", i), 64'(idle), 64'(vecs[i].idl));
        end

        // both requesters on the same cycle right after reset: wb0 first
        do_reset();
        drive(1, 5, 32'h11, 1, 5, 32'h22);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk_port("same_cycle.first", 1, 5, 32'h11);
        tick();
        chk_port("same_cycle.second", 1, 5, 32'h22);
        tick();
        chk("same_cycle.after_en", 64'(rg_wrt_en), 0);

        // continuous contention: writes alternate 0,1,0,1 and never bubble
        do_reset();
        begin
            int n0, n1;
            logic acc0, acc1;
            n0 = 0;
            n1 = 0;
            for (int k = 1; k <= 8; k++) begin
                drive(1, 5'd10, 32'h100 + 32'(n0), 1, 5'd11, 32'h200 + 32'(n1));
                acc0 = wb0_ready;
                acc1 = wb1_ready;
                tick();
                if (acc0) n0++;
                if (acc1) n1++;
                if (k >= 2) begin
                    if (k % 2 == 0)
                        chk_port($sformatf("alt%0d", k), 1, 5'd10, 32'h100 + 32'((k - 2) / 2));
                    else
                        chk_port($sformatf("alt%0d", k), 1, 5'd11, 32'h200 + 32'((k - 3) / 2));
                end
            end
            drive(0, 0, 0, 0, 0, 0);
        end

        // wb1 waits behind wb0, a newer wb0 entry arrives, older wb1 still goes first
        do_reset();
        drive(1, 1, 32'hA, 1, 2, 32'hB);
        tick();
        chk("age.wb1_stalled", 64'(wb1_ready), 0);
        drive(1, 1, 32'hC, 1, 2, 32'hB);
        tick();
        chk_port("age.first", 1, 1, 32'hA);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk_port("age.older_wb1", 1, 2, 32'hB);
        tick();
        chk_port("age.younger_wb0", 1, 1, 32'hC);
        tick();
        chk("age.idle", 64'(idle), 1);

        // asynchronous reset with both slots full
        do_reset();
        drive(1, 4, 32'hAAAA0001, 1, 6, 32'hBBBB0002);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        chk("async.pre_en", 64'(rg_wrt_en), 1);
        #3;
        reset = 1'b1;
        drive(1, 7, 32'h77, 1, 8, 32'h88);
        #1;
        chk_port("async.immediate", 0, 0, 0);
        chk("async.wb0_ready", 64'(wb0_ready), 1);
        chk("async.wb1_ready", 64'(wb1_ready), 1);
        chk("async.idle", 64'(idle), 1);
        tick();
        tick();
        chk("async.held_idle", 64'(idle), 1);
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("async.post%0d.en", k), 64'(rg_wrt_en), 0);
            chk($sformatf("async.post%0d.idle", k), 64'(idle), 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 5, register address width; DATA_W, 32, write data width.
REQ-002 Clock and reset SHALL be one clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 wb0_valid  input  1  requester 0 (ALU writeback) offers a write.
REQ-006 wb0_ready  output  1  arbiter accepts requester 0 write this cycle.
REQ-007 wb0_addr  input  ADDR_W  requester 0 destination register.
REQ-008 wb0_data  input  DATA_W  requester 0 write data.
REQ-009 wb1_valid, wb1_ready, wb1_addr, wb1_data SHALL mirror REQ-005..008 for requester 1 (load writeback).
REQ-010 rg_wrt_en  output  1  registered write enable to the register file write port.
REQ-011 rg_wrt_addr  output  ADDR_W  registered write address.
REQ-012 rg_wrt_data  output  DATA_W  registered write data.
REQ-013 idle  output  1  high when both slots are empty and rg_wrt_en is low.

Function
REQ-014 Each requester SHALL own a one-entry slot (valid, addr, data, age bit); a handshake completes on a rising edge where valid and ready are both high.
REQ-015 wbN_ready SHALL equal (slot N empty) OR (slot N granted this cycle); it SHALL depend only on registered state, never on wbN_valid.
REQ-016 The grant SHALL be combinational from slot state: one occupied slot wins outright; with both occupied, the older slot wins; with equal age, the round-robin pointer decides.
REQ-017 Round-robin pointer SHALL point to the requester not granted last; reset value is requester 0.
REQ-018 On a grant edge, the granted slot's addr/data SHALL load into rg_wrt_addr/rg_wrt_data with rg_wrt_en=1, and the slot SHALL clear unless refilled on the same edge.
REQ-019 On an edge with no grant, rg_wrt_en SHALL be 0; rg_wrt_addr/rg_wrt_data SHALL hold their previous values.
REQ-020 Latency SHALL be exactly one edge from slot accept to rg_wrt_en high, when uncontested.
REQ-021 Throughput SHALL be one write per cycle on the port; each requester sustains one write per cycle when the other is idle.
REQ-022 Same-edge acceptance into both slots SHALL mark them equal age; acceptance into an empty slot while the other is occupied SHALL mark the new entry younger.
REQ-023 Equal or different addresses SHALL be handled identically; write ordering between requesters SHALL follow the age rules only.
REQ-024 A slot occupied for 2 or more cycles SHALL win on the next grant (guaranteed by the age rule; no starvation).

Reset
REQ-025 Reset SHALL clear both slots, set the pointer to 0, and drive rg_wrt_en=0, rg_wrt_addr=0, rg_wrt_data=0, wb0_ready=wb1_ready=1, idle=1.
REQ-026 Reset asserted mid-operation SHALL discard pending slot contents; no partial write SHALL issue after reset deasserts.
REQ-027 During reset, handshakes SHALL NOT complete.

Configuration
REQ-028 Macro RF_ARB_X0_DROP_EN SHALL control the handling of writes to address 0.
REQ-029 With the macro defined, a write to address 0 SHALL be accepted and consume its grant, but rg_wrt_en SHALL stay 0 for it.
REQ-030 Without the macro, a write to address 0 SHALL be forwarded like any other write.

Structure
REQ-031 Package rf_arb_pkg SHALL hold ADDR_W/DATA_W defaults, the requester-id enum (REQ_ALU=0, REQ_LSU=1) and the slot struct typedef.
REQ-032 Sub-module rf_arb_slot SHALL implement one slot (storage, age bit, ready) and SHALL be instantiated twice.

Verification
REQ-033 Scenario: wb0 only, addr=3, data=0xDEADBEEF accepted at edge 1 -> rg_wrt_en=1, addr=3, data=0xDEADBEEF after edge 2; idle=1 after edge 3.
REQ-034 Scenario: both valid same cycle (wb0 addr=5/0x11, wb1 addr=5/0x22) after reset -> wb0 written first, wb1 next cycle; final write data 0x22.
REQ-035 Scenario: both valid continuously for 8 cycles -> grants alternate 0,1,0,1...; rg_wrt_en high every cycle after the first.
REQ-036 Scenario: wb1 arrives one cycle before wb0 while wb1 is stalled -> older wb1 granted first regardless of pointer.
REQ-037 Scenario: write to addr=0 -> rg_wrt_en stays 0 with RF_ARB_X0_DROP_EN, pulses 1 without it; wb0_ready behaves identically in both builds.
REQ-038 Scenario: reset asserted asynchronously with both slots full -> outputs zero immediately; no rg_wrt_en pulse after release.
